// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational palette lookup among NUM_REQ
// pixel requesters; two-stage pipeline returns {R,G,B} tagged with requester ID.
module palette_lookup_arbiter #(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned ID_W            = 2,
  parameter logic [7:0]  TRANSPARENT_IDX = 8'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_index,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           pal_index,
  input  logic [11:0]          pal_rgb,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [11:0]          rsp_rgb,
  output logic                 rsp_transparent,
  output logic                 busy
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned RGB_W = 12;
  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = SEL_W + 1;

  logic [SEL_W-1:0] r_rr_ptr;
  logic             r_s1_valid;
  logic [IDX_W-1:0] r_pal_index;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_s1_transp;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [RGB_W-1:0] r_rsp_rgb;
  logic             r_rsp_transp;
  logic             r_busy;

  logic [NUM_REQ-1:0] w_grant;
  logic [SEL_W-1:0]   w_gnt_pos;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_xfer;
  logic [SUM_W-1:0]   w_sum;
  logic [SEL_W-1:0]   w_pos;
  logic [IDX_W-1:0]   w_sel_index;

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
  always_comb begin
    w_grant   = '0;
    w_gnt_pos = '0;
    w_gnt_id  = '0;
    w_xfer    = 1'b0;
    w_sum     = '0;
    w_pos     = '0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_sum = SUM_W'(r_rr_ptr) + SUM_W'(k);
        if (w_sum >= SUM_W'(NUM_REQ)) begin
          w_sum = w_sum - SUM_W'(NUM_REQ);
        end
        w_pos = SEL_W'(w_sum);
        if (!w_xfer && req_valid[w_pos]) begin
          w_grant[w_pos] = 1'b1;
          w_gnt_pos      = w_pos;
          w_gnt_id       = ID_W'(w_pos);
          w_xfer         = 1'b1;
        end
      end
    end
  end

  // Select the granted requester's palette index
  always_comb begin
    w_sel_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_index = req_index[i*IDX_W +: IDX_W];
      end
    end
  end

  assign req_ready = w_grant;

  // Pointer, stage 1 (index to palette) and stage 2 (RGB response) registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_s1_valid   <= 1'b0;
      r_pal_index  <= '0;
      r_s1_id      <= '0;
      r_s1_transp  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_rgb    <= '0;
      r_rsp_transp <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_rr_ptr    <= (w_gnt_pos == SEL_W'(NUM_REQ - 1)) ? '0 : w_gnt_pos + SEL_W'(1);
        r_s1_valid  <= 1'b1;
        r_pal_index <= w_sel_index;
        r_s1_id     <= w_gnt_id;
        r_s1_transp <= (w_sel_index == TRANSPARENT_IDX);
      end else begin
        // pal_index holds so the palette does not toggle needlessly
        r_s1_valid  <= 1'b0;
      end
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_rgb    <= pal_rgb;
        r_rsp_id     <= r_s1_id;
        r_rsp_transp <= r_s1_transp;
      end
      // Next-cycle view of s1_valid | rsp_valid
      r_busy <= w_xfer | r_s1_valid;
    end
  end

  assign pal_index       = r_pal_index;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_id          = r_rsp_id;
  assign rsp_rgb         = r_rsp_rgb;
  assign rsp_transparent = r_rsp_transp;
  assign busy            = r_busy;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Self-checking bench: directed table, hand sequences and constrained-random
// traffic compared against a transaction-level reference model.
module tb_palette_lookup_arbiter;

  localparam int N = 3;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  req_valid;
  logic [23:0] req_index;
  logic [2:0]  req_ready;
  logic [7:0]  pal_index;
  logic [11:0] pal_rgb;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_rgb;
  logic        rsp_transparent;
  logic        busy;

  palette_lookup_arbiter #(.NUM_REQ(3), .ID_W(2), .TRANSPARENT_IDX(8'd0)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .pal_index(pal_index), .pal_rgb(pal_rgb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb),
    .rsp_transparent(rsp_transparent), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Palette contents
  function automatic logic [11:0] palf(input logic [7:0] i);
    if (i == 8'h00)      return 12'hFFF;
    else if (i == 8'h03) return 12'hF36;
    else                 return {i[3:0], i[7:4], i[3:0] ^ i[7:4]};
  endfunction

  assign pal_rgb = palf(pal_index);

  // Reference model state: outstanding responses with the cycle they appear
  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [11:0] rgb;
    logic        tr;
  } rsp_t;

  rsp_t        q[$];
  int          checks;
  int          failures;
  int          cyc;
  int          m_ptr;
  logic [1:0]  last_id;
  logic [11:0] last_rgb;
  logic        last_tr;
  logic [7:0]  m_pal;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Round robin: first requesting index at or after the pointer
  function automatic logic [2:0] model_grant(input logic en, input logic [2:0] v, input int ptr);
    logic [2:0] res;
    res = '0;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (ptr + k) % N;
      if (res == 3'b000 && en && v[p]) res = 3'(1 << p);
    end
    return res;
  endfunction

  // One clock cycle: drive, check grant, clock, update model, check outputs
  task automatic step(input logic en, input logic rst, input logic [2:0] v,
                      input logic [23:0] idx, output logic [2:0] rdy);
    logic [2:0] eg;
    int         g;
    logic [7:0] gi;
    logic       busy_e;
    logic       hit;
    enable    = en;
    reset     = rst;
    req_valid = v;
    req_index = idx;
    #1;
    eg  = model_grant(en, v, m_ptr);
    rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(eg));
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      q.delete();
      m_ptr    = 0;
      last_id  = '0;
      last_rgb = '0;
      last_tr  = 1'b0;
      m_pal    = '0;
    end else if (eg != 3'b000) begin
      g = 0;
      for (int i = 0; i < N; i++) if (eg[i]) g = i;
      gi = idx[g*8 +: 8];
      q.push_back('{due: cyc + 1, id: 2'(g), rgb: palf(gi), tr: (gi == 8'h00)});
      m_pal = gi;
      m_ptr = (g + 1) % N;
    end
    busy_e = 1'b0;
    foreach (q[i]) if (q[i].due == cyc || q[i].due == cyc + 1) busy_e = 1'b1;
    hit = (q.size() > 0) && (q[0].due == cyc);
    if (hit) begin
      last_id  = q[0].id;
      last_rgb = q[0].rgb;
      last_tr  = q[0].tr;
      void'(q.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(hit));
    chk("rsp_id", 32'(rsp_id), 32'(last_id));
    chk("rsp_rgb", 32'(rsp_rgb), 32'(last_rgb));
    chk("rsp_transparent", 32'(rsp_transparent), 32'(last_tr));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("pal_index", 32'(pal_index), 32'(m_pal));
  endtask

  typedef struct {
    logic       en;
    logic [2:0] v;
    logic [2:0] rdy;
    logic       rv;
    logic [1:0] id;
  } vec_t;

  vec_t        tbl[15];
  logic [2:0]  r;
  logic [23:0] IDX;
  logic [2:0]  pend;
  logic [23:0] pidx;
  int          waitc[N];

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    req_valid = '0;
    req_index = '0;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    m_ptr     = 0;
    last_id   = '0;
    last_rgb  = '0;
    last_tr   = 1'b0;
    m_pal     = '0;
    IDX       = {8'h00, 8'h03, 8'h10};

    // all-valid round robin, then enable gating
    tbl[0]  = '{1'b1, 3'b111, 3'b001, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 3'b111, 3'b010, 1'b1, 2'd0};
    tbl[2]  = '{1'b1, 3'b111, 3'b100, 1'b1, 2'd1};
    tbl[3]  = '{1'b1, 3'b111, 3'b001, 1'b1, 2'd2};
    tbl[4]  = '{1'b1, 3'b111, 3'b010, 1'b1, 2'd0};
    tbl[5]  = '{1'b1, 3'b111, 3'b100, 1'b1, 2'd1};
    tbl[6]  = '{1'b1, 3'b000, 3'b000, 1'b1, 2'd2};
    tbl[7]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd2};
    tbl[8]  = '{1'b1, 3'b111, 3'b001, 1'b0, 2'd0};
    tbl[9]  = '{1'b1, 3'b111, 3'b010, 1'b1, 2'd0};
    tbl[10] = '{1'b0, 3'b111, 3'b000, 1'b1, 2'd1};
    tbl[11] = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd1};
    tbl[12] = '{1'b0, 3'b111, 3'b000, 1'b0, 2'd1};
    tbl[13] = '{1'b1, 3'b111, 3'b100, 1'b0, 2'd1};
    tbl[14] = '{1'b1, 3'b000, 3'b000, 1'b1, 2'd2};

    // Reset, then idle
    step(1'b0, 1'b1, 3'b000, 24'h0, r);
    step(1'b0, 1'b1, 3'b000, 24'h0, r);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 3'b000, 24'h0, r);

    // Single requester 1 with index 03
    step(1'b1, 1'b0, 3'b010, {8'h00, 8'h03, 8'h00}, r);
    chk("single_ready", 32'(r), 32'(3'b010));
    step(1'b1, 1'b0, 3'b000, 24'h0, r);
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd1);
    chk("single_rsp_rgb", 32'(rsp_rgb), 32'h0F36);
    chk("single_rsp_transp", 32'(rsp_transparent), 32'd0);
    step(1'b1, 1'b0, 3'b000, 24'h0, r);
    chk("single_rsp_drop", 32'(rsp_valid), 32'd0);

    // Table from a fresh reset
    step(1'b0, 1'b1, 3'b000, 24'h0, r);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].en, 1'b0, tbl[i].v, IDX, r);
      chk("tbl_ready", 32'(r), 32'(tbl[i].rdy));
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk("tbl_rsp_id", 32'(rsp_id), 32'(tbl[i].id));
        chk("tbl_rsp_transp", 32'(rsp_transparent), 32'(tbl[i].id == 2'd2));
        chk("tbl_rsp_rgb", 32'(rsp_rgb),
            32'((tbl[i].id == 2'd0) ? 12'h011 : (tbl[i].id == 2'd1) ? 12'hF36 : 12'hFFF));
      end
    end

    // Reset the cycle after a handshake: response is discarded
    step(1'b1, 1'b0, 3'b111, IDX, r);
    step(1'b0, 1'b1, 3'b000, IDX, r);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'b000, IDX, r);
      chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
    end
    step(1'b1, 1'b0, 3'b111, IDX, r);
    chk("post_reset_grant0", 32'(r), 32'(3'b001));
    step(1'b1, 1'b0, 3'b000, IDX, r);

    // Random traffic with hold-until-granted requesters
    pend = '0;
    pidx = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 500; c++) begin
      logic en;
      logic rst;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pidx[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        end
      end
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step(en, rst, pend, pidx, r);
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          pend[i]  = 1'b0;
          waitc[i] = 0;
        end else if (pend[i] && r[i]) begin
          chk("rr_wait_bound", 32'(waitc[i] < N), 32'd1);
          pend[i]  = 1'b0;
          waitc[i] = 0;
        end else if (pend[i] && en) begin
          waitc[i]++;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
